wb_mux_ctrl: RTL and testbench

- Wishbone classic-cycle slave (responder) in the user project area; it terminates the management-SoC firmware accesses that drive the design multiplexer.
- Holds the mux control registers, a scratch register, a free-running cycle counter and a fail flag that goes out on mprj_io[37].
- Provides a 4-deep mailbox FIFO that passes 32-bit words from firmware to the selected design over a valid/ready handshake.

---
 rtl/wb_mux_ctrl_pkg.sv | 39 +++
 rtl/wb_mux_mbox_fifo.sv | 95 +++++++++
 rtl/wb_mux_ctrl.sv | 147 ++++++++++++++
 tb/tb_wb_mux_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_mux_ctrl_pkg.sv
// Shared definitions for the design-multiplexer Wishbone slave.
// Contents: register byte offsets (decoded from adr[7:2]), CTRL and MBSTAT
// bit positions, the default ID value, and a byte-select merge helper.
package wb_mux_ctrl_pkg;

    localparam logic [7:0] OFF_ID      = 8'h00;
    localparam logic [7:0] OFF_CTRL    = 8'h04;
    localparam logic [7:0] OFF_SCRATCH = 8'h08;
    localparam logic [7:0] OFF_CYCLES  = 8'h0C;
    localparam logic [7:0] OFF_MBOX    = 8'h10;
    localparam logic [7:0] OFF_MBSTAT  = 8'h14;

    localparam int CTRL_EN_BIT   = 8;
    localparam int CTRL_RST_BIT  = 9;
    localparam int CTRL_FAIL_BIT = 31;

    localparam int MBSTAT_FULL_BIT  = 8;
    localparam int MBSTAT_EMPTY_BIT = 9;
    localparam int MBSTAT_OVF_BIT   = 16;

    localparam logic [31:0] DEFAULT_ID_VALUE = 32'h4D55_5801;

    // Replace only the bytes whose select bit is set.
    function automatic logic [31:0] sel_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_val[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_mux_mbox_fifo.sv
// Parameterised show-ahead synchronous FIFO used as a mailbox.
// Ports: clk/rst_n (async active-low), push_i/push_data_i, pop_i,
// ovf_clr_i (clears sticky overflow), data_o (head word, 0 when empty),
// count_o, full_o, empty_o, overflow_o (set by a push that was dropped).
module wb_mux_mbox_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             ovf_clr_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             overflow_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             full_s, empty_s, do_push_s, do_pop_s;

    assign full_s  = (count_q == CNT_W'(DEPTH));
    assign empty_s = (count_q == '0);
    // A pop on an empty FIFO is ignored, so a same-cycle push still lands.
    assign do_pop_s  = pop_i & ~empty_s;
    // When full, the push is accepted only if a pop frees a slot this cycle.
    assign do_push_s = push_i & (~full_s | do_pop_s);

    // Next-state for storage, pointers, occupancy and sticky overflow.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // A dropped push wins over a simultaneous clear request.
        if (push_i && !do_push_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // FIFO state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    assign data_o     = empty_s ? '0 : mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign full_o     = full_s;
    assign empty_o    = empty_s;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/wb_mux_ctrl.sv
// Wishbone classic slave that controls the design multiplexer.
// Ports: wb_clk_i/wb_rst_ni (async active-low), wbs_* Wishbone slave
// interface (1-cycle registered ack), design_sel_o/design_en_o/design_rst_no
// selected-design controls, fail_o (to mprj_io[37]), and the firmware-to-
// design mailbox mbox_data_o/mbox_valid_o/mbox_ready_i.
module wb_mux_ctrl
    import wb_mux_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter logic [31:0] ID_VALUE   = DEFAULT_ID_VALUE,
    parameter int          SEL_W      = 4,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    output logic [SEL_W-1:0] design_sel_o,
    output logic             design_en_o,
    output logic             design_rst_no,
    output logic             fail_o,
    output logic [31:0]      mbox_data_o,
    output logic             mbox_valid_o,
    input  logic             mbox_ready_i
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             ack_q, ack_d;
    logic [31:0]      dat_q, dat_d;
    logic [31:0]      ctrl_q, ctrl_d;
    logic [31:0]      scratch_q, scratch_d;
    logic [31:0]      cycles_q, cycles_d;
    logic             hit_s, wr_s, push_s, ovf_clr_s;
    logic [7:0]       off_s;
    logic [31:0]      rd_data_s, mbstat_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic             fifo_full_s, fifo_empty_s, fifo_ovf_s;
    logic             unused_s;

    // The ~ack term stops a held strobe from being accepted twice.
    assign hit_s     = wbs_stb_i & wbs_cyc_i & ~ack_q &
                       (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign wr_s      = hit_s & wbs_we_i;
    assign off_s     = {wbs_adr_i[7:2], 2'b00};
    assign push_s    = wr_s & (off_s == OFF_MBOX);
    assign ovf_clr_s = wr_s & (off_s == OFF_MBSTAT) & wbs_dat_i[MBSTAT_OVF_BIT];
    assign unused_s  = ^wbs_adr_i[1:0];

    wb_mux_mbox_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_mbox (
        .clk         (wb_clk_i),
        .rst_n       (wb_rst_ni),
        .push_i      (push_s),
        .push_data_i (wbs_dat_i),
        .pop_i       (mbox_ready_i),
        .ovf_clr_i   (ovf_clr_s),
        .data_o      (mbox_data_o),
        .count_o     (fifo_count_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s),
        .overflow_o  (fifo_ovf_s)
    );

    // Assemble the mailbox status word.
    always_comb begin
        mbstat_s                   = 32'h0;
        mbstat_s[CNT_W-1:0]        = fifo_count_s;
        mbstat_s[MBSTAT_FULL_BIT]  = fifo_full_s;
        mbstat_s[MBSTAT_EMPTY_BIT] = fifo_empty_s;
        mbstat_s[MBSTAT_OVF_BIT]   = fifo_ovf_s;
    end

    // Read data multiplexer; MBOX and unmapped offsets read as zero.
    always_comb begin
        rd_data_s = 32'h0;
        case (off_s)
            OFF_ID:      rd_data_s = ID_VALUE;
            OFF_CTRL:    rd_data_s = ctrl_q;
            OFF_SCRATCH: rd_data_s = scratch_q;
            OFF_CYCLES:  rd_data_s = cycles_q;
            OFF_MBSTAT:  rd_data_s = mbstat_s;
            default:     rd_data_s = 32'h0;
        endcase
    end

    // Next-state for bus response, control registers and cycle counter.
    always_comb begin
        ack_d = hit_s;
        if (hit_s && !wbs_we_i) begin
            dat_d = rd_data_s;
        end else begin
            dat_d = 32'h0;
        end
        if (wr_s && (off_s == OFF_CTRL)) begin
            ctrl_d = sel_merge(ctrl_q, wbs_dat_i, wbs_sel_i);
        end else begin
            ctrl_d = ctrl_q;
        end
        if (wr_s && (off_s == OFF_SCRATCH)) begin
            scratch_d = sel_merge(scratch_q, wbs_dat_i, wbs_sel_i);
        end else begin
            scratch_d = scratch_q;
        end
        // Any write to CYCLES zeroes it on the ack edge; counting resumes after.
        if (wr_s && (off_s == OFF_CYCLES)) begin
            cycles_d = 32'h0;
        end else begin
            cycles_d = cycles_q + 32'd1;
        end
    end

    // Register bank and bus response flops.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q     <= 1'b0;
            dat_q     <= 32'h0;
            ctrl_q    <= 32'h0;
            scratch_q <= 32'h0;
            cycles_q  <= 32'h0;
        end else begin
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            ctrl_q    <= ctrl_d;
            scratch_q <= scratch_d;
            cycles_q  <= cycles_d;
        end
    end

    assign wbs_ack_o     = ack_q;
    assign wbs_dat_o     = dat_q;
    assign design_sel_o  = ctrl_q[SEL_W-1:0];
    assign design_en_o   = ctrl_q[CTRL_EN_BIT];
    // The design only leaves reset while enabled and not explicitly held.
    assign design_rst_no = ctrl_q[CTRL_EN_BIT] & ~ctrl_q[CTRL_RST_BIT];
    assign fail_o        = ctrl_q[CTRL_FAIL_BIT];
    assign mbox_valid_o  = ~fifo_empty_s;

endmodule

// File: tb/tb_wb_mux_ctrl.sv
// Self-checking bench for wb_mux_ctrl: directed steps followed by a random
// phase checked against a queue-based model of the register file and mailbox.
module tb_wb_mux_ctrl;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat_o;
    logic [3:0]  dsel;
    logic        den, drst_n, fail;
    logic [31:0] mdata;
    logic        mvalid, mready;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state
    logic [31:0] m_ctrl, m_scratch;
    logic        m_ovf;
    logic [31:0] m_q[$];

    always #5 clk = ~clk;

    wb_mux_ctrl dut (
        .wb_clk_i      (clk),
        .wb_rst_ni     (rst_n),
        .wbs_stb_i     (stb),
        .wbs_cyc_i     (cyc),
        .wbs_we_i      (we),
        .wbs_sel_i     (sel),
        .wbs_adr_i     (adr),
        .wbs_dat_i     (wdat),
        .wbs_ack_o     (ack),
        .wbs_dat_o     (rdat_o),
        .design_sel_o  (dsel),
        .design_en_o   (den),
        .design_rst_no (drst_n),
        .fail_o        (fail),
        .mbox_data_o   (mdata),
        .mbox_valid_o  (mvalid),
        .mbox_ready_i  (mready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge one idle cycle after the ack.
    task automatic xfer(input logic w, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] d, input logic pop,
                        output logic [31:0] r, output int lat);
        stb = 1'b1; cyc = 1'b1; we = w; sel = s; adr = a; wdat = d; mready = pop;
        lat = 0; r = 32'h0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                lat = i;
                r = rdat_o;
                break;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0; mready = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s,
                      input logic pop = 1'b0);
        logic [31:0] r;
        int lat;
        xfer(1'b1, s, BASE + {24'd0, off}, d, pop, r, lat);
        chk("write ack latency", lat, 32'd1);
    endtask

    task automatic rd(input logic [7:0] off, output logic [31:0] r);
        int lat;
        xfer(1'b0, 4'hF, BASE + {24'd0, off}, 32'h0, 1'b0, r, lat);
        chk("read ack latency", lat, 32'd1);
    endtask

    function automatic logic [31:0] m_mbstat();
        int c;
        c = m_q.size();
        return {15'd0, m_ovf, 6'd0, (c == 0), (c == 4), 5'd0, 3'(c)};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~mask) | (n & mask);
    endfunction

    function automatic logic [31:0] ctrl_outs();
        return {25'd0, dsel, den, drst_n, fail};
    endfunction

    function automatic logic [31:0] m_ctrl_outs();
        return {25'd0, m_ctrl[3:0], m_ctrl[8], m_ctrl[8] & ~m_ctrl[9], m_ctrl[31]};
    endfunction

    function automatic logic [31:0] all_outs();
        return {ack, dsel, den, drst_n, fail, mvalid, 23'd0} | rdat_o | mdata;
    endfunction

    initial begin
        logic [31:0] r;
        int          lat;
        int          op;
        logic [3:0]  s;
        logic [31:0] d;
        logic [7:0]  off;

        rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
        adr = 32'h0; wdat = 32'h0; mready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset ack", {31'd0, ack}, 32'd0);
        chk("reset dat", rdat_o, 32'd0);
        chk("reset ctrl outs", ctrl_outs(), 32'd0);
        chk("reset mbox", {mdata[30:0], mvalid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ID register
        rd(8'h00, r);
        chk("id value", r, 32'h4D55_5801);
        chk("dat zero outside ack", rdat_o, 32'd0);
        chk("fail/rst_n after id", {30'd0, fail, drst_n}, 32'd0);

        // CTRL
        wr(8'h04, 32'h0000_0103, 4'hF);
        chk("ctrl 0x103 outs", ctrl_outs(), {25'd0, 4'd3, 1'b1, 1'b1, 1'b0});
        wr(8'h04, 32'h0000_0200, 4'h2);
        chk("ctrl sel2 rst_n", {31'd0, drst_n}, 32'd0);
        chk("ctrl sel2 design_sel", {28'd0, dsel}, 32'd3);

        // SCRATCH, unmapped, foreign address
        wr(8'h08, 32'hDEAD_BEEF, 4'hF);
        wr(8'h08, 32'h0000_0011, 4'h1);
        rd(8'h08, r);
        chk("scratch byte merge", r, 32'hDEAD_BE11);
        rd(8'h40, r);
        chk("unmapped read", r, 32'd0);
        xfer(1'b0, 4'hF, 32'h3000_0100, 32'h0, 1'b0, r, lat);
        chk("foreign address no ack", lat, 32'd0);

        // Overflow with ready low
        for (int i = 1; i <= 5; i++) wr(8'h10, i, 4'hF);
        rd(8'h14, r);
        chk("mbstat full+ovf", r, 32'h0001_0104);
        chk("head word 1", mdata, 32'd1);
        mready = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            chk("drain order", mdata, k);
        end
        @(negedge clk);
        chk("drained valid", {31'd0, mvalid}, 32'd0);
        mready = 1'b0;
        wr(8'h14, 32'h0001_0000, 4'hF);
        rd(8'h14, r);
        chk("mbstat ovf cleared", r, 32'h0000_0200);

        // Push and pop together while full
        for (int i = 11; i <= 14; i++) wr(8'h10, i, 4'hF);
        wr(8'h10, 32'd6, 4'h0, 1'b1);
        rd(8'h14, r);
        chk("mbstat push+pop full", r, 32'h0000_0104);
        chk("head after push+pop", mdata, 32'd12);
        mready = 1'b1;
        @(negedge clk); chk("order 13", mdata, 32'd13);
        @(negedge clk); chk("order 14", mdata, 32'd14);
        @(negedge clk); chk("order 6", mdata, 32'd6);
        @(negedge clk); chk("empty after 6", {31'd0, mvalid}, 32'd0);
        mready = 1'b0;

        // Fail flag and cycle counter
        wr(8'h04, 32'h8000_0000, 4'h8);
        chk("fail flag", {31'd0, fail}, 32'd1);
        wr(8'h0C, 32'h1234_5678, 4'hF);
        // Cleared on the ack edge; returned one cycle later, two more waits,
        // and the read samples before its own hit edge: 1 + 2 = 3.
        repeat (2) @(negedge clk);
        rd(8'h0C, r);
        chk("cycles after clear", r, 32'd3);

        // Random phase against the model
        m_ctrl = 32'h8000_0203; m_scratch = 32'hDEAD_BE11; m_ovf = 1'b0;
        m_q.delete();
        for (int it = 0; it < 300; it++) begin
            op = $urandom_range(0, 7);
            s  = 4'($urandom_range(0, 15));
            d  = $urandom;
            case (op)
                0: begin
                    wr(8'h08, d, s);
                    m_scratch = merge(m_scratch, d, s);
                end
                1: begin
                    wr(8'h04, d, s);
                    m_ctrl = merge(m_ctrl, d, s);
                    chk("rand ctrl outs", ctrl_outs(), m_ctrl_outs());
                end
                2: begin
                    wr(8'h10, d, s);
                    if (m_q.size() == 4) m_ovf = 1'b1;
                    else m_q.push_back(d);
                end
                3: begin rd(8'h08, r); chk("rand scratch", r, m_scratch); end
                4: begin rd(8'h04, r); chk("rand ctrl", r, m_ctrl); end
                5: begin rd(8'h14, r); chk("rand mbstat", r, m_mbstat()); end
                6: begin
                    chk("rand valid", {31'd0, mvalid}, {31'd0, m_q.size() != 0});
                    chk("rand head", mdata, (m_q.size() != 0) ? m_q[0] : 32'd0);
                    mready = 1'b1;
                    @(negedge clk);
                    mready = 1'b0;
                    if (m_q.size() != 0) void'(m_q.pop_front());
                end
                default: begin
                    off = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(6, 63) << 2);
                    wr(off, d, s);
                    rd(8'h00, r);
                    chk("rand id unchanged", r, 32'h4D55_5801);
                end
            endcase
        end

        // Reset in the middle of a pending transfer
        wr(8'h10, 32'h55, 4'hF);
        stb = 1'b1; cyc = 1'b1; we = 1'b1; sel = 4'hF; adr = BASE + 32'h4; wdat = 32'h0000_0105;
        #2 rst_n = 1'b0;
        #1 chk("mid-reset outputs", all_outs(), 32'd0);
        @(posedge clk); #1;
        chk("mid-reset no ack", {31'd0, ack}, 32'd0);
        @(negedge clk);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        rd(8'h04, r);
        chk("ctrl after reset", r, 32'd0);
        rd(8'h14, r);
        chk("mbstat after reset", r, 32'h0000_0200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
